// File: rtl/umi_mem_atomic.sv
// rtl/umi_mem_atomic.sv - single-port UMI memory target with atomics and error accounting
//
// Packet layout (requests and responses):
//   [7:0]     opcode      [11:8]    size        [12]    burst
//   [31:13]   user        [95:32]   dstaddr     [159:96] srcaddr
//   [255:160] data (word is zero-extended/truncated into this field)
// Request opcodes: 0x00 invalid, 0x02 read, 0x05 write-ack,
//   0xA4 atomic with A = 0 swap, 1 add, 2 and, 3 or, 4 xor, 5 max, 6 min (A>6 invalid),
//   anything else (posted write, stream, signal, ...) behaves as a posted write.
module umi_mem_atomic #(
  parameter int         ADDR_WIDTH  = 8,
  parameter int         DATA_WIDTH  = 32,
  parameter logic [7:0] RESP_OPCODE = 8'h01,
  parameter logic [7:0] ACK_OPCODE  = 8'h09,
  parameter int         ERR_WIDTH   = 8
) (
  input  logic                 clk,
  input  logic                 nreset,
  input  logic [255:0]         umi_rx_packet,
  input  logic                 umi_rx_valid,
  output logic                 umi_rx_ready,
  output logic [255:0]         umi_tx_packet,
  output logic                 umi_tx_valid,
  input  logic                 umi_tx_ready,
  output logic [ERR_WIDTH-1:0] err_count
);

  localparam logic [3:0] RESP_SIZE = 4'($clog2(DATA_WIDTH / 8));
  localparam logic [7:0] OP_INVALID = 8'h00;
  localparam logic [7:0] OP_READ    = 8'h02;
  localparam logic [7:0] OP_WRACK   = 8'h05;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} resp_state_e;

  resp_state_e state_q, state_d;

  logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];

  logic [7:0]            rx_opcode;
  logic [63:0]           rx_dstaddr;
  logic [63:0]           rx_srcaddr;
  logic [255:0]          rx_data_field;
  logic [DATA_WIDTH-1:0] rx_data;
  logic [ADDR_WIDTH-1:0] idx;
  logic                  in_range;
  logic [DATA_WIDTH-1:0] old_word;
  logic                  accept;
  logic                  is_read, is_wrack, is_atomic, cmd_invalid;
  logic [3:0]            atype;
  logic [DATA_WIDTH-1:0] atomic_result;

  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  resp_en;
  logic                  err_inc;

  logic [7:0]            resp_opcode_q, resp_opcode_d;
  logic [63:0]           resp_dstaddr_q, resp_dstaddr_d;
  logic [DATA_WIDTH-1:0] resp_data_q, resp_data_d;
  logic [ERR_WIDTH-1:0]  err_q, err_d;
  logic [255:0]          resp_data_ext;

  logic unused_rx;
  logic unused_tx;

  assign rx_opcode     = umi_rx_packet[7:0];
  assign rx_dstaddr    = umi_rx_packet[95:32];
  assign rx_srcaddr    = umi_rx_packet[159:96];
  assign rx_data_field = {160'd0, umi_rx_packet[255:160]};
  assign rx_data       = rx_data_field[DATA_WIDTH-1:0];
  assign unused_rx     = ^{umi_rx_packet[31:8], rx_data_field};

  assign idx      = rx_dstaddr[ADDR_WIDTH-1:0];
  assign in_range = (rx_dstaddr >> ADDR_WIDTH) == 64'd0;
  assign old_word = mem_q[idx];

  assign atype       = rx_opcode[7:4];
  assign is_read     = (rx_opcode == OP_READ);
  assign is_wrack    = (rx_opcode == OP_WRACK);
  assign is_atomic   = (rx_opcode[3:0] == 4'h4);
  assign cmd_invalid = (rx_opcode == OP_INVALID) || (is_atomic && (atype > 4'd6));

  assign umi_rx_ready = (state_q == EMPTY) || umi_tx_ready;
  assign accept       = umi_rx_valid && umi_rx_ready;

  // Atomic read-modify-write value; min/max compare signed and keep old on a tie
  always_comb begin
    atomic_result = rx_data;
    case (atype)
      4'd1:    atomic_result = old_word + rx_data;
      4'd2:    atomic_result = old_word & rx_data;
      4'd3:    atomic_result = old_word | rx_data;
      4'd4:    atomic_result = old_word ^ rx_data;
      4'd5:    atomic_result = ($signed(rx_data) > $signed(old_word)) ? rx_data : old_word;
      4'd6:    atomic_result = ($signed(rx_data) < $signed(old_word)) ? rx_data : old_word;
      default: atomic_result = rx_data;
    endcase
  end

  // Request execution: memory write enable, response fields and error increment
  always_comb begin
    mem_we         = 1'b0;
    mem_wdata      = rx_data;
    resp_en        = 1'b0;
    resp_opcode_d  = RESP_OPCODE;
    resp_dstaddr_d = rx_srcaddr;
    resp_data_d    = '0;
    err_inc        = 1'b0;
    if (accept) begin
      if (cmd_invalid) begin
        err_inc = 1'b1;
      end else begin
        err_inc = !in_range;
        if (is_read) begin
          resp_en     = 1'b1;
          resp_data_d = in_range ? old_word : '0;
        end else if (is_atomic) begin
          resp_en     = 1'b1;
          resp_data_d = in_range ? old_word : '0;
          mem_we      = in_range;
          mem_wdata   = atomic_result;
        end else if (is_wrack) begin
          resp_en       = 1'b1;
          resp_opcode_d = ACK_OPCODE;
          mem_we        = in_range;
        end else begin
          mem_we = in_range;
        end
      end
    end
  end

  // Response slot next state and saturating error counter
  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    if (resp_en) begin
      state_d = FULL;
    end else if ((state_q == FULL) && umi_tx_ready) begin
      state_d = EMPTY;
    end
    if (err_inc && (err_q != {ERR_WIDTH{1'b1}})) begin
      err_d = err_q + ERR_WIDTH'(1);
    end
  end

  // Response register and error counter; a pending response is dropped on reset
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q        <= EMPTY;
      resp_opcode_q  <= '0;
      resp_dstaddr_q <= '0;
      resp_data_q    <= '0;
      err_q          <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      if (resp_en) begin
        resp_opcode_q  <= resp_opcode_d;
        resp_dstaddr_q <= resp_dstaddr_d;
        resp_data_q    <= resp_data_d;
      end
    end
  end

  // Memory array is not reset; update shares the edge with response capture
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[idx] <= mem_wdata;
    end
  end

  assign resp_data_ext = 256'(resp_data_q);
  assign unused_tx     = ^resp_data_ext[255:96];
  assign umi_tx_valid  = (state_q == FULL);
  assign err_count     = err_q;
  assign umi_tx_packet = {resp_data_ext[95:0], 64'd0, resp_dstaddr_q, 19'd0, 1'b0,
                          RESP_SIZE, resp_opcode_q};

endmodule

// File: doc/umi_mem_atomic.md
Name: umi_mem_atomic

Overview:
Parametrised single-port UMI memory target. It accepts 256-bit UMI request packets and supports posted writes, acknowledged writes, reads, and the seven atomic read-modify-write operations. It returns response packets to the requester's srcaddr. It sits behind a UMI router or switchboard queue as a generic memory endpoint, with error accounting and fully registered responses.

Parameters:
ADDR_WIDTH, 8, word-address bits; depth = 2**ADDR_WIDTH words.
DATA_WIDTH, 32, word width in bits; legal values are 8, 16, 32, 64, 128, 256.
RESP_OPCODE, 8'h01, opcode carried by read and atomic responses.
ACK_OPCODE, 8'h09, opcode carried by write-ack responses (write-response encoding of umi_pack).
ERR_WIDTH, 8, width of the saturating error counter.

Ports:
clk  input  1  clock; all state updates on rising edge.
nreset  input  1  asynchronous, active-low reset.
umi_rx_packet  input  256  request packet, decoded with umi_unpack.
umi_rx_valid  input  1  request valid.
umi_rx_ready  output  1  request ready.
umi_tx_packet  output  256  response packet, built with umi_pack from registered fields.
umi_tx_valid  output  1  response valid.
umi_tx_ready  input  1  response ready.
err_count  output  ERR_WIDTH  saturating count of invalid or out-of-range requests.

Behaviour:
- Reset (nreset low, asynchronous):
  - umi_tx_valid=0, err_count=0.
  - Registered response fields (opcode, dstaddr, data) = 0.
  - Memory contents are not reset.
  - A pending response is discarded.
- Handshake:
  - A transfer occurs only on a clock edge with valid && ready.
  - umi_rx_ready = !umi_tx_valid || umi_tx_ready (combinational; enables back-to-back requests at full rate).
  - umi_tx_valid, once set, holds with a stable packet until umi_tx_ready.
  - Simultaneous tx drain and new rx accept: the new response replaces the old one and tx_valid stays 1.
- Address:
  - idx = rx_dstaddr[ADDR_WIDTH-1:0] (word addressed).
  - In range iff rx_dstaddr[63:ADDR_WIDTH]==0.
- Per accepted request (request data = rx_data[DATA_WIDTH-1:0], old = mem[idx] before the edge):
  - write-normal: mem[idx] <= data; no response.
  - write-ack: mem[idx] <= data; response with ACK_OPCODE, data 0.
  - read: response with RESP_OPCODE, data = old zero-extended to 256 bits.
  - atomic: mem[idx] <= f(old, data); response data = old.
    - swap: f = data.
    - add: f = (old + data) mod 2**DATA_WIDTH.
    - and / or / xor: bitwise.
    - min / max: signed two's-complement compare of DATA_WIDTH bits; tie keeps old.
  - Every response: dstaddr = rx_srcaddr, srcaddr = 0, size = $clog2(DATA_WIDTH/8), user = 0, burst = 0.
  - Response appears with tx_valid=1 on the cycle after accept (latency 1).
- Ordering:
  - Memory update and response capture happen on the same edge.
  - Back-to-back requests to the same idx see the prior request's result.
- Errors:
  - cmd_invalid: request is accepted, dropped with no response, and err_count += 1.
  - Out-of-range address: no memory update and err_count += 1.
    - Posted write: dropped.
    - Read, atomic or write-ack: still responds, with data 0, so the requester never hangs.
  - err_count saturates at all-ones.
  - Unsupported opcodes not flagged invalid by umi_unpack (e.g. stream, signal) are treated as write-normal.
- No internal state machine beyond the one-entry response register.
  - States: EMPTY (tx_valid=0) and FULL (tx_valid=1).
  - EMPTY->FULL on an accept that produces a response.
  - FULL->EMPTY on tx_ready with no new responding accept.
  - FULL->FULL on tx_ready plus a responding accept, or no tx_ready.

Test Plan:
- Reset mid-response: issue a read, hold tx_ready=0, pulse nreset low -> tx_valid drops to 0 asynchronously, err_count=0, and earlier memory writes are preserved.
- Posted write then read: write 0xDEADBEEF to addr 0x10, then read addr 0x10 with srcaddr 0x1234 -> one cycle after accept, response has data 0xDEADBEEF, dstaddr 0x1234, RESP_OPCODE.
- Atomic add and max: mem[3]=0x7FFFFFFF.
  - Atomic add 1 -> response 0x7FFFFFFF, mem[3]=0x80000000.
  - Then atomic max 0x00000005 -> response 0x80000000, mem[3]=0x00000005.
- Back-pressure: 3 consecutive reads with tx_ready=0 -> only the first is accepted and rx_ready=0 thereafter. Release tx_ready -> the remaining two complete one per cycle, in order, with correct data.
- Write-ack at full rate: 4 back-to-back write-acks with tx_ready=1 -> 4 ACK_OPCODE responses on consecutive cycles, rx_ready held at 1 throughout.
- Errors:
  - Read to dstaddr 0x100 (ADDR_WIDTH=8) -> response with data 0, err_count=1.
  - Invalid command -> no response, err_count=2.
  - With ERR_WIDTH=2 and 5 errors -> err_count saturates at 3.
